// File: rtl/par2ser_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
package par2ser_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

    function automatic int cnt_w(input int length);
        return $clog2(length);
    endfunction

endpackage

// File: rtl/par2ser_hold.sv
// One-word holding buffer with valid flag and captured bit order.
module par2ser_hold
    import par2ser_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [LENGTH-1:0] wr_data,
    input  logic              wr_dir,
    output logic              hold_valid,
    output logic [LENGTH-1:0] hold_data,
    output logic              hold_dir
);

    // A write in the same cycle as a read refills the buffer, so write wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_dir   <= LSB_FIRST;
        end else begin
            if (wr) begin
                hold_data <= wr_data;
                hold_dir  <= wr_dir;
            end
            if (wr)
                hold_valid <= 1'b1;
            else if (rd)
                hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial converter: valid/ready word input, one bit per enabled
// clock out, with a one-word holding buffer for gapless streaming.
module par2ser
    import par2ser_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              direct,
    input  logic              ivalid,
    input  logic [LENGTH-1:0] idata,
    output logic              iready,
    output logic              ovalid,
    output logic              odata,
    output logic              olast
);

    localparam int                CNT_W    = cnt_w(LENGTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

    state_t            state_q, state_d;
    logic [LENGTH-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic              dir_q;

    logic              hold_valid, hold_dir;
    logic [LENGTH-1:0] hold_data;

    logic              accept, at_last, free;
    logic              load, load_hold, hold_wr;
    logic [LENGTH-1:0] load_data;
    logic              load_dir;

    assign iready  = enable & ~hold_valid;
    assign accept  = ivalid & iready;
    assign at_last = (state_q == SHIFT) && (cnt == LAST_CNT);
    assign free    = (state_q == IDLE) || at_last;

    // Shifter prefers the held word; a fresh word bypasses only when hold is empty.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_hold = 1'b0;
        hold_wr   = 1'b0;
        load_data = idata;
        load_dir  = direct;
        if (enable) begin
            if (free) begin
                if (hold_valid) begin
                    load      = 1'b1;
                    load_hold = 1'b1;
                    load_data = hold_data;
                    load_dir  = hold_dir;
                    hold_wr   = accept;
                    state_d   = SHIFT;
                end else if (accept) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                hold_wr = accept;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg  <= '0;
            cnt   <= '0;
            dir_q <= LSB_FIRST;
        end else if (enable) begin
            if (load) begin
                sreg  <= load_data;
                cnt   <= '0;
                dir_q <= load_dir;
            end else if (state_q == SHIFT) begin
                sreg <= (dir_q == MSB_FIRST) ? {sreg[LENGTH-2:0], 1'b0}
                                             : {1'b0, sreg[LENGTH-1:1]};
                cnt  <= at_last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    assign ovalid = (state_q == SHIFT) & enable;
    assign odata  = (dir_q == MSB_FIRST) ? sreg[LENGTH-1] : sreg[0];
    assign olast  = at_last;

    par2ser_hold #(
        .LENGTH(LENGTH)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .wr        (hold_wr),
        .rd        (load_hold),
        .wr_data   (idata),
        .wr_dir    (direct),
        .hold_valid(hold_valid),
        .hold_data (hold_data),
        .hold_dir  (hold_dir)
    );

endmodule

// File: tb/tb_par2ser.sv
// Self-checking bench for par2ser: directed vector table, corner sequences,
// loopback deserialisation and a randomized run against a bit-stream model.
module tb_par2ser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0, direct = 1'b0, ivalid = 1'b0;
    logic [7:0] idata = '0;
    logic       iready, ovalid, odata, olast;

    logic s_iready, s_ovalid, s_odata, s_olast;
    int   n_cmp = 0;
    int   n_bad = 0;

    par2ser #(
        .LENGTH(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .direct(direct),
        .ivalid(ivalid),
        .idata (idata),
        .iready(iready),
        .ovalid(ovalid),
        .odata (odata),
        .olast (olast)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en, iv;
        logic [7:0] d;
        logic       dr;
        logic       ir, ov, od, ol;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic en, iv, input logic [7:0] d, input logic dr,
                                input logic ir, ov, od, ol);
        vec_t v;
        v.en = en; v.iv = iv; v.d = d; v.dr = dr;
        v.ir = ir; v.ov = ov; v.od = od; v.ol = ol;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive inputs for one cycle, sample outputs mid-cycle, then step past the edge.
    task automatic cyc(input logic en, iv, input logic [7:0] d, input logic dr);
        enable = en; ivalid = iv; idata = d; direct = dr;
        #1;
        s_iready = iready; s_ovalid = ovalid; s_odata = odata; s_olast = olast;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w1, w2;
        logic [7:0] lw[3];
        logic [7:0] got[$];
        logic [7:0] sh;
        logic       exp_bits[$];
        logic       exp_last[$];
        int unsigned idx;

        // ---------------- vector table ----------------
        w1 = 8'hD5;
        add(1, 1, w1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(1, 0, 8'h00, 1, 1, 1, w1[7-k], k == 7);
        add(1, 0, 8'h00, 1, 1, 0, 0, 0);

        w1 = 8'hA5; w2 = 8'h3C;
        add(1, 1, w1, 1, 1, 0, 0, 0);
        add(1, 1, w2, 1, 1, 1, w1[7], 0);
        for (int k = 1; k < 8; k++) add(1, 0, 8'h00, 1, 0, 1, w1[7-k], k == 7);
        for (int k = 0; k < 8; k++) add(1, 0, 8'h00, 1, 1, 1, w2[7-k], k == 7);
        add(1, 0, 8'h00, 1, 1, 0, 0, 0);

        w1 = 8'h01;
        add(1, 1, w1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(1, 0, 8'h00, 0, 1, 1, w1[k], k == 7);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);

        // ---------------- reset state ----------------
        enable = 1'b1;
        #12;
        reset = 1'b0;
        @(posedge clock);
        #1;
        #1;
        chk("rst_iready", 0, iready, 1);
        chk("rst_ovalid", 0, ovalid, 0);
        chk("rst_odata", 0, odata, 0);
        chk("rst_olast", 0, olast, 0);
        enable = 1'b0;
        #1;
        chk("rst_iready_dis", 0, iready, 0);
        chk("rst_ovalid_dis", 0, ovalid, 0);
        @(posedge clock);
        #1;

        // ---------------- table run ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].en, tbl[i].iv, tbl[i].d, tbl[i].dr);
            chk("tbl_iready", i, s_iready, tbl[i].ir);
            chk("tbl_ovalid", i, s_ovalid, tbl[i].ov);
            chk("tbl_olast", i, s_olast, tbl[i].ol);
            if (tbl[i].ov) chk("tbl_odata", i, s_odata, tbl[i].od);
        end

        // ---------------- stall mid-word ----------------
        w1 = 8'hF0;
        cyc(1, 1, w1, 1);
        chk("stall_accept", 0, s_iready, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 8'h00, 1);
            chk("stall_ov", k, s_ovalid, 1);
            chk("stall_od", k, s_odata, w1[7-k]);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 8'h77, 0);
            chk("stall_ov_dis", k, s_ovalid, 0);
            chk("stall_ir_dis", k, s_iready, 0);
            chk("stall_od_hold", k, s_odata, w1[3]);
            chk("stall_ol_hold", k, s_olast, 0);
        end
        for (int k = 4; k < 8; k++) begin
            cyc(1, 0, 8'h00, 1);
            chk("resume_ov", k, s_ovalid, 1);
            chk("resume_od", k, s_odata, w1[7-k]);
            chk("resume_ol", k, s_olast, k == 7);
        end
        cyc(1, 0, 8'h00, 1);
        chk("stall_after_ov", 0, s_ovalid, 0);

        // ---------------- reset mid-word with full hold ----------------
        cyc(1, 1, 8'hFF, 1);
        cyc(1, 1, 8'h00, 1);
        chk("mrst_bit0", 0, s_odata, 1);
        cyc(1, 0, 8'h00, 1);
        chk("mrst_hold_full", 0, s_iready, 0);
        cyc(1, 0, 8'h00, 1);
        chk("mrst_bit2_ov", 0, s_ovalid, 1);
        reset = 1'b1;
        #2;
        chk("mrst_iready", 0, iready, 1);
        chk("mrst_ovalid", 0, ovalid, 0);
        chk("mrst_odata", 0, odata, 0);
        chk("mrst_olast", 0, olast, 0);
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 12; k++) begin
            cyc(1, 0, 8'h00, 1);
            chk("mrst_quiet", k, s_ovalid, 0);
        end

        // ---------------- loopback through a behavioural ser2par ----------------
        lw[0] = 8'hD5; lw[1] = 8'h5A; lw[2] = 8'hFF;
        idx = 0;
        sh  = '0;
        for (int c = 0; c < 100 && got.size() < 3; c++) begin
            cyc(1, idx < 3, (idx < 3) ? lw[idx] : 8'h00, 1);
            if (s_ovalid) begin
                sh = {sh[6:0], s_odata};
                if (s_olast) got.push_back(sh);
            end
            if (idx < 3 && s_iready) idx++;
        end
        chk("loop_count", 0, got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) chk("loop_word", k, got[k], lw[k]);
        for (int k = 0; k < 3; k++) cyc(1, 0, 8'h00, 1);

        // ---------------- randomized run against a bit-stream model ----------------
        for (int c = 0; c < 3000; c++) begin
            logic       en, iv, dr, exp_ir;
            logic [7:0] d;
            int         pend;
            en     = ($urandom_range(0, 9) != 0);
            iv     = ($urandom_range(0, 2) != 0);
            d      = 8'($urandom);
            dr     = 1'($urandom);
            pend   = exp_bits.size();
            exp_ir = en && (pend <= 8);
            cyc(en, iv, d, dr);
            chk("rnd_iready", c, s_iready, exp_ir);
            chk("rnd_ovalid", c, s_ovalid, en && (pend > 0));
            if (s_ovalid && pend > 0) begin
                chk("rnd_odata", c, s_odata, exp_bits[0]);
                chk("rnd_olast", c, s_olast, exp_last[0]);
                void'(exp_bits.pop_front());
                void'(exp_last.pop_front());
            end
            if (iv && exp_ir) begin
                for (int k = 0; k < 8; k++) begin
                    exp_bits.push_back(dr ? d[7-k] : d[k]);
                    exp_last.push_back(k == 7);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
